// File: rtl/sram_axi_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 bridge: FSM state encodings,
// default transaction IDs and the fixed single-beat AXI attribute values.
package sram_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
    localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK       = 2'b00;
    localparam logic [3:0] AXI_CACHE      = 4'd0;
    localparam logic [2:0] AXI_PROT       = 3'd0;

    // SRAM size encodes bytes as 2^size, which is exactly AXI's AxSIZE.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/axi_wr_ch.sv
// Write channel of the SRAM-to-AXI3 bridge: accepts one data-port write, drives
// AW and W independently until both handshake, then waits for the B response.
module axi_wr_ch
    import sram_axi_pkg::*;
#(
    parameter logic [3:0] ID = DATA_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [1:0]  req_size,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic        busy,
    output logic [31:0] pend_addr,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    wr_state_e   state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  size_q, size_d;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (req && resetn) begin
                    addr_ok = 1'b1;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    size_d  = req_size;
                    state_d = W_REQ;
                end
            end
            W_REQ: begin
                // AW and W may complete in either order or together.
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = W_RESP;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_ok = 1'b1;
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Payload is only observed while a valid is high, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        size_q  <= size_d;
    end

    assign busy      = (state_q != W_IDLE);
    assign pend_addr = addr_q;
    assign awid      = ID;
    assign awaddr    = addr_q;
    assign awsize    = axi_size(size_q);
    assign wid       = ID;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wlast     = 1'b1;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3 master:
// one outstanding read (data port wins arbitration) and one outstanding write.
// Optional build macro BRIDGE_RAW_BLOCK_EN holds off data reads that hit a pending write word.
module sram_axi_bridge
    import sram_axi_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
    parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_e   rd_state_q, rd_state_d;
    logic        owner_data_q, owner_data_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [1:0]  rd_size_q, rd_size_d;

    logic        data_rd_req, inst_rd_req, raw_hit;
    logic        rd_data_addr_ok, rd_inst_ok, rd_data_ok;
    logic        wr_req, wr_addr_ok, wr_data_ok, wr_busy;
    logic [31:0] wr_pend_addr;
    logic        unused_ok;

`ifdef BRIDGE_RAW_BLOCK_EN
    assign raw_hit   = wr_busy && (data_sram_addr[31:2] == wr_pend_addr[31:2]);
    assign unused_ok = ^{rid, rresp, rlast, bid, bresp, inst_sram_wstrb,
                         inst_sram_wdata, wr_pend_addr[1:0]};
`else
    // The slave is responsible for read-after-write ordering in this build.
    assign raw_hit   = 1'b0;
    assign unused_ok = ^{rid, rresp, rlast, bid, bresp, inst_sram_wstrb,
                         inst_sram_wdata, wr_busy, wr_pend_addr};
`endif

    assign data_rd_req = data_sram_req && !data_sram_wr && !raw_hit;
    assign inst_rd_req = inst_sram_req && !inst_sram_wr;
    assign wr_req      = data_sram_req && data_sram_wr;

    always_comb begin
        rd_state_d        = rd_state_q;
        owner_data_d      = owner_data_q;
        rd_addr_d         = rd_addr_q;
        rd_size_d         = rd_size_q;
        rd_data_addr_ok   = 1'b0;
        inst_sram_addr_ok = 1'b0;
        rd_inst_ok        = 1'b0;
        rd_data_ok        = 1'b0;
        arvalid           = 1'b0;
        rready            = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (resetn && data_rd_req) begin
                    rd_data_addr_ok = 1'b1;
                    owner_data_d    = 1'b1;
                    rd_addr_d       = data_sram_addr;
                    rd_size_d       = data_sram_size;
                    rd_state_d      = R_ADDR;
                end else if (resetn && inst_rd_req) begin
                    inst_sram_addr_ok = 1'b1;
                    owner_data_d      = 1'b0;
                    rd_addr_d         = inst_sram_addr;
                    rd_size_d         = inst_sram_size;
                    rd_state_d        = R_ADDR;
                end
            end
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rready = 1'b1;
                // Routing follows the latched owner; rid is not decoded.
                if (rvalid) begin
                    rd_data_ok = owner_data_q;
                    rd_inst_ok = !owner_data_q;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q   <= R_IDLE;
            owner_data_q <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            owner_data_q <= owner_data_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_addr_q <= rd_addr_d;
        rd_size_q <= rd_size_d;
    end

    axi_wr_ch #(
        .ID (DATA_ID)
    ) u_wr_ch (
        .clk       (clk),
        .resetn    (resetn),
        .req       (wr_req),
        .req_size  (data_sram_size),
        .req_wstrb (data_sram_wstrb),
        .req_addr  (data_sram_addr),
        .req_wdata (data_sram_wdata),
        .addr_ok   (wr_addr_ok),
        .data_ok   (wr_data_ok),
        .busy      (wr_busy),
        .pend_addr (wr_pend_addr),
        .awid      (awid),
        .awaddr    (awaddr),
        .awsize    (awsize),
        .awvalid   (awvalid),
        .awready   (awready),
        .wid       (wid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    assign inst_sram_data_ok = rd_inst_ok;
    assign inst_sram_rdata   = rd_inst_ok ? rdata : 32'd0;
    assign data_sram_addr_ok = rd_data_addr_ok | wr_addr_ok;
    assign data_sram_data_ok = rd_data_ok | wr_data_ok;
    assign data_sram_rdata   = rd_data_ok ? rdata : 32'd0;

    assign arid    = owner_data_q ? DATA_ID : INST_ID;
    assign araddr  = rd_addr_q;
    assign arsize  = axi_size(rd_size_q);
    assign arlen   = AXI_LEN;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign awlen   = AXI_LEN;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: directed scenarios plus randomized
// traffic, compared each cycle against a transaction-level model of both ports.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Outstanding read and write as the model sees them.
    bit          rd_v, rd_ar, rd_own_data;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    bit          wr_v, wr_aw, wr_w;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic [1:0]  wr_size;

    int          p_ar = 100, p_r = 100, p_aw = 100, p_w = 100, p_b = 100;
    bit          fix_rdata = 1'b0;
    logic [31:0] fixed_rdata = 32'd0;

    int          n_cmp = 0, n_err = 0;
    int          inst_ok_cnt = 0, data_ok_cnt = 0;
    bit          obs_inst_aok, obs_data_aok;
    logic [31:0] last_inst_rdata = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic clear_model();
        rd_v = 1'b0; rd_ar = 1'b0; rd_own_data = 1'b0;
        wr_v = 1'b0; wr_aw = 1'b0; wr_w = 1'b0;
    endtask

    task automatic idle_cpu();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_wstrb = 4'h0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_wstrb = 4'h0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    endtask

    task automatic rand_cpu();
        inst_sram_req   = pct(40);
        inst_sram_wr    = pct(10);
        inst_sram_size  = 2'($urandom_range(0, 2));
        inst_sram_wstrb = 4'($urandom);
        inst_sram_addr  = 32'h1c00_0000 | ($urandom & 32'h3c);
        inst_sram_wdata = $urandom;
        data_sram_req   = pct(50);
        data_sram_wr    = pct(50);
        data_sram_size  = 2'($urandom_range(0, 2));
        data_sram_wstrb = 4'($urandom);
        data_sram_addr  = 32'h0000_0100 | ($urandom & 32'h1f);
        data_sram_wdata = $urandom;
    endtask

    // AXI slave behaviour, decided from the model right after a rising edge.
    task automatic drive_slave();
        arready = pct(p_ar);
        awready = pct(p_aw);
        wready  = pct(p_w);
        rvalid  = rd_v && rd_ar && pct(p_r);
        rdata   = fix_rdata ? fixed_rdata : $urandom;
        rid     = 4'($urandom);
        rresp   = 2'($urandom);
        rlast   = 1'b1;
        // Never answer a data read and a data write in the same cycle.
        bvalid  = wr_v && wr_aw && wr_w && pct(p_b) && !(rvalid && rd_own_data);
        bid     = 4'($urandom);
        bresp   = 2'($urandom);
    endtask

    task automatic check_cycle();
        bit raw, data_rd, exp_iaok, exp_daok, rd_resp, wr_resp;
        raw = 1'b0;
`ifdef BRIDGE_RAW_BLOCK_EN
        raw = wr_v && (data_sram_addr[31:2] == wr_addr[31:2]);
`endif
        data_rd  = data_sram_req && !data_sram_wr && !raw;
        exp_daok = resetn && data_sram_req && (data_sram_wr ? !wr_v : (!rd_v && !raw));
        exp_iaok = resetn && !rd_v && inst_sram_req && !inst_sram_wr && !data_rd;
        rd_resp  = rd_v && rd_ar && rvalid;
        wr_resp  = wr_v && wr_aw && wr_w && bvalid;

        chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(exp_iaok));
        chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(exp_daok));
        chk("arvalid", 32'(arvalid), 32'(rd_v && !rd_ar));
        if (rd_v && !rd_ar) begin
            chk("araddr", araddr, rd_addr);
            chk("arid", 32'(arid), rd_own_data ? 32'd1 : 32'd0);
            chk("arsize", 32'(arsize), 32'(rd_size));
        end
        chk("rready", 32'(rready), 32'(rd_v && rd_ar));
        chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(rd_resp && !rd_own_data));
        chk("inst_rdata", inst_sram_rdata, (rd_resp && !rd_own_data) ? rdata : 32'd0);
        chk("data_data_ok", 32'(data_sram_data_ok), 32'((rd_resp && rd_own_data) || wr_resp));
        chk("data_rdata", data_sram_rdata, (rd_resp && rd_own_data) ? rdata : 32'd0);
        chk("awvalid", 32'(awvalid), 32'(wr_v && !wr_aw));
        chk("wvalid", 32'(wvalid), 32'(wr_v && !wr_w));
        if (wr_v && !wr_aw) begin
            chk("awaddr", awaddr, wr_addr);
            chk("awid", 32'(awid), 32'd1);
            chk("awsize", 32'(awsize), 32'(wr_size));
        end
        if (wr_v && !wr_w) begin
            chk("wdata", wdata, wr_data);
            chk("wstrb", 32'(wstrb), 32'(wr_strb));
            chk("wlast", 32'(wlast), 32'd1);
            chk("wid", 32'(wid), 32'd1);
        end
        chk("bready", 32'(bready), 32'(wr_v && wr_aw && wr_w));

        obs_inst_aok = inst_sram_addr_ok;
        obs_data_aok = data_sram_addr_ok;
        if (inst_sram_data_ok) begin
            inst_ok_cnt++;
            last_inst_rdata = inst_sram_rdata;
        end
        if (data_sram_data_ok) data_ok_cnt++;

        if (!resetn) begin
            clear_model();
        end else begin
            if (rd_v) begin
                if (!rd_ar) begin
                    if (arready) rd_ar = 1'b1;
                end else if (rvalid) begin
                    rd_v = 1'b0;
                end
            end else if (exp_daok && !data_sram_wr) begin
                rd_v = 1'b1; rd_ar = 1'b0; rd_own_data = 1'b1;
                rd_addr = data_sram_addr; rd_size = data_sram_size;
            end else if (exp_iaok) begin
                rd_v = 1'b1; rd_ar = 1'b0; rd_own_data = 1'b0;
                rd_addr = inst_sram_addr; rd_size = inst_sram_size;
            end
            if (wr_v) begin
                if (wr_aw && wr_w) begin
                    if (bvalid) wr_v = 1'b0;
                end else begin
                    if (!wr_aw && awready) wr_aw = 1'b1;
                    if (!wr_w && wready) wr_w = 1'b1;
                end
            end else if (exp_daok && data_sram_wr) begin
                wr_v = 1'b1; wr_aw = 1'b0; wr_w = 1'b0;
                wr_addr = data_sram_addr; wr_data = data_sram_wdata;
                wr_strb = data_sram_wstrb; wr_size = data_sram_size;
            end
        end
    endtask

    // Called just after a rising edge with CPU inputs already set.
    task automatic step();
        drive_slave();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic all_ready(input int p);
        p_ar = p; p_r = p; p_aw = p; p_w = p; p_b = p;
    endtask

    initial begin
        int c0, d0, cycles;
        bit seen;
        clear_model();
        idle_cpu();
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        drive_slave();
        @(posedge clk);
        #1;
        step();
        step();
        chk("arlen", 32'(arlen), 32'd0);
        chk("awlen", 32'(awlen), 32'd0);
        chk("arburst", 32'(arburst), 32'd1);
        chk("awburst", 32'(awburst), 32'd1);
        chk("lock_cache_prot", 32'({arlock, awlock, arcache, awcache, arprot, awprot}), 32'd0);
        resetn = 1'b1;
        idle_cpu();
        step();

        // Minimum-latency instruction fetch.
        all_ready(100);
        fix_rdata = 1'b1;
        fixed_rdata = 32'h0280_0000;
        c0 = inst_ok_cnt;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2;
        step();
        idle_cpu();
        step();
        step();
        chk("d1_inst_ok_count", 32'(inst_ok_cnt - c0), 32'd1);
        chk("d1_inst_rdata", last_inst_rdata, 32'h0280_0000);
        fix_rdata = 1'b0;

        // Simultaneous reads: data wins, inst waits for the read FSM to idle.
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0010;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0200;
        cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            cycles++;
            data_sram_req = 1'b0;
            seen = obs_inst_aok;
        end
        inst_sram_req = 1'b0;
        chk("d2_inst_grant_cycle", 32'(cycles), 32'd4);
        step();
        step();
        step();

        // Write with W lagging AW by two cycles.
        d0 = data_ok_cnt;
        p_w = 0;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h100;
        data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hcafe_f00d; data_sram_size = 2'd1;
        step();
        idle_cpu();
        step();
        step();
        p_w = 100;
        step();
        step();
        step();
        chk("d3_write_ok_count", 32'(data_ok_cnt - d0), 32'd1);

        // Inst read overlapped with a data write.
        c0 = inst_ok_cnt;
        d0 = data_ok_cnt;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0020;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h180;
        data_sram_wstrb = 4'hf; data_sram_wdata = 32'h1234_5678;
        step();
        idle_cpu();
        step();
        step();
        step();
        chk("d4_inst_ok_count", 32'(inst_ok_cnt - c0), 32'd1);
        chk("d4_data_ok_count", 32'(data_ok_cnt - d0), 32'd1);

`ifdef BRIDGE_RAW_BLOCK_EN
        // Read of a word with a pending write is held until the write completes.
        p_b = 0;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h102;
        data_sram_wstrb = 4'b1100;
        step();
        data_sram_wr = 1'b0; data_sram_addr = 32'h100;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | obs_data_aok;
        end
        chk("d5_raw_held", 32'(seen), 32'd0);
        p_b = 100;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step();
            seen = obs_data_aok;
        end
        chk("d5_raw_released", 32'(seen), 32'd1);
        idle_cpu();
        step();
        step();
        step();
`endif

        // Reset while waiting in R_DATA, with requests still asserted.
        p_r = 0;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0030;
        step();
        idle_cpu();
        step();
        step();
        chk("d6_in_data_phase", 32'(rready), 32'd1);
        resetn = 1'b0;
        clear_model();
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        step();
        resetn = 1'b1;
        idle_cpu();
        all_ready(100);
        c0 = inst_ok_cnt;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0040;
        step();
        idle_cpu();
        step();
        step();
        chk("d6_read_after_reset", 32'(inst_ok_cnt - c0), 32'd1);

        // Randomized traffic with varying slave responsiveness.
        for (int seg = 0; seg < 12; seg++) begin
            p_ar = int'($urandom_range(20, 100));
            p_r  = int'($urandom_range(20, 100));
            p_aw = int'($urandom_range(20, 100));
            p_w  = int'($urandom_range(20, 100));
            p_b  = int'($urandom_range(20, 100));
            for (int i = 0; i < 300; i++) begin
                if (seg == 6 && i == 150) begin
                    resetn = 1'b0;
                    clear_model();
                    rand_cpu();
                    step();
                    resetn = 1'b1;
                end
                rand_cpu();
                step();
            end
        end

        // Drain outstanding transactions.
        idle_cpu();
        all_ready(100);
        for (int i = 0; i < 20 && (rd_v || wr_v); i++) step();
        chk("drain_done", 32'(rd_v || wr_v), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
